// File: rtl/clk_power_sequencer.sv
// clk_power_sequencer: sequences the external clock generator's oscillator
// enable, clock-phase enable and oscillator-stable indication through cold
// boot, STOP-mode shutdown and wake-up, and holds the CPU in sync reset on
// cold boot.
//
// Ports:
//   CLK        free-running reference clock
//   RESET      synchronous active-high reset
//   STOP_REQ   CPU STOP request (level, sampled only in RUN)
//   WAKE       wake event (level, acted on in STOP_CLK / STOPPED)
//   OSC_ENA    oscillator enable
//   CLK_ENA    clock-phase enable
//   OSC_STABLE oscillator settled
//   SYNC_RESET CPU synchronous reset request
//   STOP_ACK   high while in STOPPED
//   SEQ_STATE  current state encoding (debug)
//
// Optional feature: define CLKSEQ_WAKE_FILTER_EN to require WAKE to be
// sampled high on 3 consecutive edges before it qualifies.
//
// Latency: every output is a flop; outputs change on the edge that enters
// the new state. No combinational path from inputs to outputs.

module clk_power_sequencer #(
  parameter int OSC_SETTLE_CYCLES = 16,
  parameter int SYNC_RESET_CYCLES = 4,
  parameter int CLK_GATE_DELAY    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       STOP_REQ,
  input  logic       WAKE,
  output logic       OSC_ENA,
  output logic       CLK_ENA,
  output logic       OSC_STABLE,
  output logic       SYNC_RESET,
  output logic       STOP_ACK,
  output logic [2:0] SEQ_STATE
);

  localparam int MAX_AB = (OSC_SETTLE_CYCLES > SYNC_RESET_CYCLES) ?
                          OSC_SETTLE_CYCLES : SYNC_RESET_CYCLES;
  localparam int MAX_P  = (MAX_AB > CLK_GATE_DELAY) ? MAX_AB : CLK_GATE_DELAY;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  // The counter holds (edges already spent in the state), so the N-th edge
  // is the one that sees N-1.
  localparam logic [CNT_W-1:0] OSC_TC  = CNT_W'(OSC_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_TC = CNT_W'(SYNC_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_TC = CNT_W'(CLK_GATE_DELAY - 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_OSC_WARM = 3'd1,
    ST_SRST     = 3'd2,
    ST_RUN      = 3'd3,
    ST_STOP_CLK = 3'd4,
    ST_STOPPED  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cold, cold_nxt;
  logic             wake_pending, wake_pending_nxt;
  logic             wake_qual;

  // Output flops: {OSC_ENA, CLK_ENA, OSC_STABLE, SYNC_RESET, STOP_ACK}
  logic [4:0]       out_q, out_nxt;

  // Output decode for a given state and cold flag. Evaluated on the next
  // state so the registered outputs line up with the state register.
  function automatic logic [4:0] decode(input state_t s, input logic c);
    logic [4:0] o;
    o = 5'b00010;
    case (s)
      ST_OFF:      o = 5'b00010;
      ST_OSC_WARM: o = {3'b100, c, 1'b0};
      ST_SRST:     o = 5'b11110;
      ST_RUN:      o = 5'b11100;
      ST_STOP_CLK: o = {3'b101, c, 1'b0};
      ST_STOPPED:  o = {3'b000, c, 1'b1};
      default:     o = 5'b00010;
    endcase
    return o;
  endfunction

`ifdef CLKSEQ_WAKE_FILTER_EN
  // Consecutive-high counter for WAKE. Only runs in the two stop states so a
  // WAKE level held during RUN cannot pre-arm the filter.
  logic [1:0] wake_cnt, wake_cnt_nxt;
  logic       in_stop;

  always_comb begin
    in_stop      = (state == ST_STOP_CLK) || (state == ST_STOPPED);
    wake_cnt_nxt = 2'd0;
    if (WAKE && in_stop) begin
      wake_cnt_nxt = (wake_cnt == 2'd3) ? 2'd3 : wake_cnt + 2'd1;
    end
    // This edge is at least the 3rd consecutive high sample.
    wake_qual = WAKE && in_stop && (wake_cnt >= 2'd2);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wake_cnt <= 2'd0;
    end else begin
      wake_cnt <= wake_cnt_nxt;
    end
  end
`else
  assign wake_qual = WAKE;
`endif

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    cold_nxt         = cold;
    wake_pending_nxt = wake_pending;

    case (state)
      ST_OFF: begin
        state_nxt = ST_OSC_WARM;
        cnt_nxt   = '0;
      end
      ST_OSC_WARM: begin
        if (cnt == OSC_TC) begin
          state_nxt = cold ? ST_SRST : ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SRST: begin
        if (cnt == SRST_TC) begin
          state_nxt = ST_RUN;
          cold_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // WAKE is deliberately not latched here.
        if (STOP_REQ) begin
          state_nxt = ST_STOP_CLK;
          cnt_nxt   = '0;
        end
      end
      ST_STOP_CLK: begin
        // A wake arriving while clocks are being gated is remembered so the
        // STOPPED visit shrinks to a single cycle.
        if (wake_qual) begin
          wake_pending_nxt = 1'b1;
        end
        if (cnt == GATE_TC) begin
          state_nxt = ST_STOPPED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_STOPPED: begin
        if (wake_qual || wake_pending) begin
          state_nxt        = ST_OSC_WARM;
          wake_pending_nxt = 1'b0;
          cnt_nxt          = '0;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase

    out_nxt = decode(state_nxt, cold_nxt);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_OFF;
      cnt          <= '0;
      cold         <= 1'b1;
      wake_pending <= 1'b0;
      out_q        <= 5'b00010;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cold         <= cold_nxt;
      wake_pending <= wake_pending_nxt;
      out_q        <= out_nxt;
    end
  end

  assign OSC_ENA    = out_q[4];
  assign CLK_ENA    = out_q[3];
  assign OSC_STABLE = out_q[2];
  assign SYNC_RESET = out_q[1];
  assign STOP_ACK   = out_q[0];
  assign SEQ_STATE  = state;

endmodule

// File: tb/tb_clk_power_sequencer.sv
// Testbench for clk_power_sequencer: directed boot/stop/wake/reset scenarios
// with literal expectations, then randomized stimulus compared every cycle
// against a behavioural model of the sequencing rules.

module tb_clk_power_sequencer;

  localparam int OSC_N  = 16;
  localparam int SRST_N = 4;
  localparam int GATE_N = 2;

  logic       CLK = 1'b0;
  logic       RESET, STOP_REQ, WAKE;
  logic       OSC_ENA, CLK_ENA, OSC_STABLE, SYNC_RESET, STOP_ACK;
  logic [2:0] SEQ_STATE;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  clk_power_sequencer #(
    .OSC_SETTLE_CYCLES(OSC_N),
    .SYNC_RESET_CYCLES(SRST_N),
    .CLK_GATE_DELAY   (GATE_N)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .STOP_REQ  (STOP_REQ),
    .WAKE      (WAKE),
    .OSC_ENA   (OSC_ENA),
    .CLK_ENA   (CLK_ENA),
    .OSC_STABLE(OSC_STABLE),
    .SYNC_RESET(SYNC_RESET),
    .STOP_ACK  (STOP_ACK),
    .SEQ_STATE (SEQ_STATE)
  );

  wire [7:0] outs = {OSC_ENA, CLK_ENA, OSC_STABLE, SYNC_RESET, STOP_ACK, SEQ_STATE};
  localparam logic [7:0] RESET_VEC = 8'b0001_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases use the published SEQ_STATE numbers; m_edges is the number of
  // edges already spent in the current phase, m_run the length of the
  // current run of high WAKE samples taken while stopping/stopped.
  int   m_ph;
  int   m_edges;
  int   m_run;
  bit   m_cold, m_pend;
  bit   armed = 0;
  bit   m_reset_edge = 0;

  function automatic logic [7:0] model_outs(input int ph, input bit cold);
    logic osc, clk, stb, srst, ack;
    osc  = (ph >= 1 && ph <= 4);
    clk  = (ph == 2 || ph == 3);
    stb  = (ph >= 2 && ph <= 4);
    srst = (ph == 0 || ph == 2) ? 1'b1 : (ph == 3 ? 1'b0 : cold);
    ack  = (ph == 5);
    return {osc, clk, stb, srst, ack, 3'(ph)};
  endfunction

  always @(posedge CLK) begin
    bit woke;
    int run_new;
    int next_ph;
    m_reset_edge = RESET;
    if (RESET) begin
      m_ph = 0; m_cold = 1; m_edges = 0; m_pend = 0; m_run = 0;
      armed = 1;
    end else if (armed) begin
      run_new = (WAKE && (m_ph == 4 || m_ph == 5)) ? m_run + 1 : 0;
`ifdef CLKSEQ_WAKE_FILTER_EN
      woke = WAKE && (run_new >= 3);
`else
      woke = WAKE;
`endif
      m_edges = m_edges + 1;
      next_ph = m_ph;
      case (m_ph)
        0: next_ph = 1;
        1: if (m_edges == OSC_N) next_ph = m_cold ? 2 : 3;
        2: if (m_edges == SRST_N) begin next_ph = 3; m_cold = 0; end
        3: if (STOP_REQ) next_ph = 4;
        4: begin
             if (woke) m_pend = 1;
             if (m_edges == GATE_N) next_ph = 5;
           end
        5: if (woke || m_pend) begin next_ph = 1; m_pend = 0; end
        default: next_ph = 0;
      endcase
      if (next_ph != m_ph) m_edges = 0;
      m_ph  = next_ph;
      m_run = run_new;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_osc = 1'b0, prev_clk = 1'b0;
  always @(negedge CLK) begin
    if (armed) begin
      chk("outputs_vs_model", outs, model_outs(m_ph, m_cold));
      chk("clk_ena_implies_osc", CLK_ENA && !(OSC_ENA && OSC_STABLE), 0);
      if (!m_reset_edge)
        chk("osc_clk_fall_same_cycle", prev_osc && !OSC_ENA && prev_clk && !CLK_ENA, 0);
      prev_osc = OSC_ENA;
      prev_clk = CLK_ENA;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // RESET already low; next edge is e1.
  task automatic cold_boot();
    step();
    chk("boot_e1_osc_ena", OSC_ENA, 1);
    chk("boot_e1_state", SEQ_STATE, 1);
    chk("boot_e1_srst", SYNC_RESET, 1);
    repeat (15) step();
    chk("boot_e16_clk_ena", CLK_ENA, 0);
    step();
    chk("boot_e17_clk_stable", {CLK_ENA, OSC_STABLE}, 2'b11);
    chk("boot_e17_state", SEQ_STATE, 2);
    repeat (3) step();
    chk("boot_e20_srst", SYNC_RESET, 1);
    step();
    chk("boot_e21_srst", SYNC_RESET, 0);
    chk("boot_e21_state", SEQ_STATE, 3);
  endtask

  task automatic stop_seq();
    STOP_REQ = 1;
    step();
    STOP_REQ = 0;
    chk("stop_s_clk_ena", CLK_ENA, 0);
    chk("stop_s_osc_ena", OSC_ENA, 1);
    chk("stop_s_state", SEQ_STATE, 4);
    step();
    chk("stop_s1_osc_ena", OSC_ENA, 1);
    step();
    chk("stop_s2_vec", {OSC_ENA, OSC_STABLE, STOP_ACK}, 3'b001);
    chk("stop_s2_state", SEQ_STATE, 5);
    step();
    chk("stop_s3_still_stopped", STOP_ACK, 1);
  endtask

  task automatic warm_wake();
    WAKE = 1;
`ifdef CLKSEQ_WAKE_FILTER_EN
    step();
    chk("filt_wake_1", STOP_ACK, 1);
    step();
    chk("filt_wake_2", STOP_ACK, 1);
`endif
    step();
    WAKE = 0;
    chk("wake_w_ack", STOP_ACK, 0);
    chk("wake_w_osc", OSC_ENA, 1);
    chk("wake_w_srst", SYNC_RESET, 0);
    repeat (15) step();
    chk("wake_w15_clk", {CLK_ENA, SYNC_RESET}, 2'b00);
    step();
    chk("wake_w16_clk", {CLK_ENA, SYNC_RESET}, 2'b10);
    chk("wake_w16_state", SEQ_STATE, 3);
  endtask

  initial begin
    RESET = 1; STOP_REQ = 0; WAKE = 0;
    repeat (3) step();
    chk("reset_vec", outs, RESET_VEC);
    RESET = 0;
    cold_boot();
    stop_seq();
    warm_wake();

`ifdef CLKSEQ_WAKE_FILTER_EN
    stop_seq();
    WAKE = 1;
    repeat (2) step();
    WAKE = 0;
    repeat (2) step();
    chk("filt_short_stays", {STOP_ACK, SEQ_STATE}, 4'b1101);
    warm_wake();
`else
    STOP_REQ = 1;
    step();
    STOP_REQ = 0;
    WAKE = 1;
    step();
    WAKE = 0;
    chk("sdwake_s1_state", SEQ_STATE, 4);
    step();
    chk("sdwake_s2_ack", STOP_ACK, 1);
    step();
    chk("sdwake_s3_ack", STOP_ACK, 0);
    chk("sdwake_s3_state", SEQ_STATE, 1);
`endif

    // Reset from mid-sequence, then reset again at e8 of the warm-up.
    RESET = 1;
    step();
    chk("midrst_any_vec", outs, RESET_VEC);
    RESET = 0;
    repeat (7) step();
    RESET = 1;
    step();
    chk("midrst_e8_vec", outs, RESET_VEC);
    RESET = 0;
    cold_boot();

    // Randomized phase, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      RESET    = ($urandom_range(0, 399) == 0);
      STOP_REQ = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) WAKE = ~WAKE;
      step();
    end
    RESET = 0; STOP_REQ = 0; WAKE = 0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
